lisnoc_router_output_arbiter: RTL and testbench

Per-output-port wormhole arbiter and output stage for the LISNoC router, one instance per output port and virtual channel. It shares one output link among all input ports: it picks a requesting input round-robin, locks the link to that input from header flit to last flit, pops flits from the input buffer via `read`, and presents them on a registered output with valid/ready flow control.

---
 rtl/lisnoc_router_output_arbiter.sv | 117 +++++++++++
 tb/tb_lisnoc_router_output_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lisnoc_router_output_arbiter.sv
// Wormhole output arbiter: round-robin pick among inputs, lock from header to last flit.
// Latency: flit popped (read high) in cycle N is on out_flit/out_valid in cycle N+1.
// Backpressure: read is suppressed while out_valid & !out_ready; out_flit is held stable.
module lisnoc_router_output_arbiter #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int PORTS           = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS-1:0]                  request,
    input  logic [PORTS*(FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH)-1:0] flit_in,
    output logic [PORTS-1:0]                  read,
    output logic [FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH-1:0] out_flit,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PORTS-1:0]                  grant,
    output logic                              proto_err
);

    localparam int FLIT_WIDTH = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
    localparam int PTR_W      = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] TYPE_HEADER  = 2'b01;
    localparam logic [1:0] TYPE_LAST    = 2'b10;
    localparam logic [1:0] TYPE_SINGLE  = 2'b11;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      rr_ptr;

    logic                  can_accept;
    logic                  found;
    int                    idx;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      rr_next;
    logic [PTR_W-1:0]      sel_port;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic [1:0]            sel_type;
    logic                  pop;

    // Round-robin search: first requester at or after rr_ptr, wrapping modulo PORTS
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = (int'(rr_ptr) + k) % PORTS;
            if (!found && request[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // Select the served input, decide whether to pop it this cycle
    always_comb begin
        can_accept = !out_valid || out_ready;
        rr_next    = (win == PTR_W'(PORTS - 1)) ? '0 : win + PTR_W'(1);
        sel_port   = (state == ST_LOCKED) ? owner : win;
        sel_flit   = flit_in[int'(sel_port)*FLIT_WIDTH +: FLIT_WIDTH];
        sel_type   = sel_flit[FLIT_WIDTH-1 -: 2];
        // Reset is folded in so a held reset never pops upstream buffers
        pop        = rst && can_accept &&
                     ((state == ST_IDLE) ? found : request[owner]);
        read       = pop ? (PORTS'(1) << sel_port) : '0;
        grant      = (state == ST_LOCKED) ? (PORTS'(1) << owner) : '0;
    end

    // Output register: load on pop, otherwise drain when downstream accepts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out_flit  <= sel_flit;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Packet lock FSM, round-robin pointer and sticky protocol error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            proto_err <= 1'b0;
        end else if (pop) begin
            if (state == ST_IDLE) begin
                case (sel_type)
                    TYPE_HEADER: begin
                        state  <= ST_LOCKED;
                        owner  <= win;
                        rr_ptr <= rr_next;
                    end
                    TYPE_SINGLE: rr_ptr <= rr_next;
                    // Stray payload/last with no open packet: forwarded but flagged
                    default:     proto_err <= 1'b1;
                endcase
            end else begin
                case (sel_type)
                    TYPE_LAST:    state <= ST_IDLE;
                    TYPE_PAYLOAD: state <= ST_LOCKED;
                    // Nested header/single inside a packet: forwarded, lock kept
                    default:      proto_err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_router_output_arbiter.sv
// Directed bench for the wormhole output arbiter with hand-computed expectations.
// Latency: checks registered outputs one cycle after the read that popped the flit.
// Backpressure: exercises out_ready stalls and owner request gaps.
module tb_lisnoc_router_output_arbiter;

    localparam int FW = 34;
    localparam logic [1:0] P = 2'b00, H = 2'b01, L = 2'b10, S = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      request;
    logic [5*FW-1:0] flit_in;
    logic [4:0]      read;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      grant;
    logic            proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    lisnoc_router_output_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .flit_in   (flit_in),
        .read      (read),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic set_flit(input int p, input logic [1:0] t, input logic [31:0] d);
        flit_in[p*FW +: FW] = mk(t, d);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] rr_rd   [4] = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
    int         rr_prev [4] = '{0, 1, 3, 1};

    initial begin
        // Reset held with every input requesting
        rst       = 1'b0;
        request   = 5'b11111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) set_flit(i, S, 32'(i));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",  read,      5'b0);
        chk("rst_flit",  out_flit,  '0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_grant", grant,     5'b0);
        chk("rst_perr",  proto_err, 1'b0);

        // First grant after release goes to input 0
        rst = 1'b1;
        #1;
        chk("first_grant", read, 5'b00001);
        cyc;

        // Round robin between inputs 1 and 3 sending singles
        request = 5'b01010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_read",  read,      rr_rd[k]);
            chk("rr_flit",  out_flit,  mk(S, 32'(rr_prev[k])));
            chk("rr_valid", out_valid, 1'b1);
            cyc;
        end
        request = 5'b00000;
        #1;
        chk("rr_last_flit", out_flit, mk(S, 32'd3));
        chk("rr_idle_read", read,     5'b0);
        cyc;
        chk("rr_drain", out_valid, 1'b0);

        // Single from input 1 moves the pointer to 2
        request = 5'b00010;
        #1;
        chk("wh_pre_read", read, 5'b00010);
        cyc;

        // Wormhole packet on input 2 while input 0 keeps requesting
        request = 5'b00101;
        set_flit(2, H, 32'hA0);
        set_flit(0, S, 32'hB0);
        #1;
        chk("wh_hdr_read",  read,  5'b00100);
        chk("wh_hdr_grant", grant, 5'b00000);
        cyc;
        set_flit(2, P, 32'hA1);
        #1;
        chk("wh_p1_read",  read,     5'b00100);
        chk("wh_p1_grant", grant,    5'b00100);
        chk("wh_p1_flit",  out_flit, mk(H, 32'hA0));
        cyc;

        // Downstream stall mid-packet
        set_flit(2, P, 32'hA2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_read",  read,      5'b0);
            chk("bp_flit",  out_flit,  mk(P, 32'hA1));
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_grant", grant,     5'b00100);
            cyc;
        end
        out_ready = 1'b1;
        #1;
        chk("wh_p2_read", read,     5'b00100);
        chk("wh_p2_flit", out_flit, mk(P, 32'hA1));
        cyc;
        set_flit(2, L, 32'hA3);
        #1;
        chk("wh_l_read", read,     5'b00100);
        chk("wh_l_flit", out_flit, mk(P, 32'hA2));
        cyc;

        // Input 0 is served right after the last flit
        request = 5'b00001;
        #1;
        chk("wh_next_read",  read,     5'b00001);
        chk("wh_next_grant", grant,    5'b00000);
        chk("wh_next_flit",  out_flit, mk(L, 32'hA3));
        cyc;
        request = 5'b00000;
        #1;
        chk("wh_b0_flit", out_flit,  mk(S, 32'hB0));
        chk("wh_perr",    proto_err, 1'b0);
        cyc;
        chk("wh_drain", out_valid, 1'b0);

        // Owner stall: input 1 locks, then goes quiet while input 4 requests
        request = 5'b00010;
        set_flit(1, H, 32'hC0);
        set_flit(4, S, 32'hD4);
        #1;
        chk("st_hdr_read", read, 5'b00010);
        cyc;
        request = 5'b10000;
        #1;
        chk("st1_read",  read,      5'b0);
        chk("st1_valid", out_valid, 1'b1);
        chk("st1_grant", grant,     5'b00010);
        cyc;
        #1;
        chk("st2_read",  read,      5'b0);
        chk("st2_valid", out_valid, 1'b0);
        chk("st2_grant", grant,     5'b00010);
        cyc;
        request = 5'b10010;
        set_flit(1, L, 32'hC1);
        #1;
        chk("st_last_read", read, 5'b00010);
        cyc;
        request = 5'b10000;
        #1;
        chk("st_in4_read",  read,     5'b10000);
        chk("st_in4_grant", grant,    5'b00000);
        chk("st_in4_flit",  out_flit, mk(L, 32'hC1));
        cyc;
        request = 5'b00000;
        #1;
        chk("st_d4_flit", out_flit, mk(S, 32'hD4));
        cyc;

        // Protocol error: payload flit with no open packet (pointer is at 0)
        request = 5'b00001;
        set_flit(0, P, 32'hE0);
        #1;
        chk("pe_read",     read,      5'b00001);
        chk("pe_perr_pre", proto_err, 1'b0);
        cyc;
        request = 5'b00000;
        #1;
        chk("pe_perr",  proto_err, 1'b1);
        chk("pe_flit",  out_flit,  mk(P, 32'hE0));
        chk("pe_valid", out_valid, 1'b1);
        cyc;
        cyc;
        // Pointer did not advance on the payload grant, so input 0 wins again
        request = 5'b00011;
        set_flit(0, S, 32'hE1);
        set_flit(1, S, 32'h1);
        #1;
        chk("pe_rr_held",    read,      5'b00001);
        chk("pe_perr_stick", proto_err, 1'b1);
        cyc;

        // Only reset clears the sticky error
        request = 5'b00000;
        rst     = 1'b0;
        #1;
        chk("pe_perr_rst", proto_err, 1'b0);
        chk("rst2_valid",  out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
